// File: rtl/fifo_pkg.sv
// fifo_pkg: default sizing for the single-clock FWFT FIFO.
//   FIFO_DSIZE - default data word width
//   FIFO_ASIZE - default address width
//   FIFO_DEPTH - derived default depth (2**FIFO_ASIZE)
package fifo_pkg;
    localparam int FIFO_DSIZE = 8;
    localparam int FIFO_ASIZE = 3;
    localparam int FIFO_DEPTH = 1 << FIFO_ASIZE;
endpackage

// File: rtl/fifo_if.sv
// fifo_if: producer/consumer handshake bundle for the FIFO.
//   winc/wdata   - write request and data (producer -> FIFO)
//   rinc         - read request (consumer -> FIFO)
//   rdata        - head entry, valid while rempty is low
//   wfull/rempty - registered status flags
// slave modport is the FIFO side, master is the user side.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;

    modport slave  (input winc, wdata, rinc, output rdata, wfull, rempty);
    modport master (output winc, wdata, rinc, input rdata, wfull, rempty);
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: 2**ASIZE x DSIZE register array.
//   clk    - write clock
//   wclken - write enable, samples wdata into mem[waddr] on rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - combinational read of mem[raddr]
// Contents are intentionally not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int ASIZE = FIFO_ASIZE
) (
    input  logic             clk,
    input  logic             wclken,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);
    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wclken) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo.sv
// fifo: single-clock first-word-fall-through FIFO.
//   clk - clock, all state changes on rising edge
//   rst - asynchronous active-high reset (pointers to 0, empty, not full)
//   bus - fifo_if slave: winc/wdata/rinc in, rdata/wfull/rempty out
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Flags are registered from the next-state pointers, so they track
// occupancy in the same cycle the pointers move.
module fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE = FIFO_DSIZE,
    parameter int ASIZE = FIFO_ASIZE
) (
    input  logic  clk,
    input  logic  rst,
    fifo_if.slave bus
);
    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             wen, ren;
    logic [DSIZE-1:0] rdata;

    always_comb begin
        // Registered flags gate the requests, even when the opposite
        // side is active in the same cycle.
        wen      = bus.winc && !wfull_q;
        ren      = bus.rinc && !rempty_q;
        wptr_d   = wptr_q + (ASIZE+1)'(wen);
        rptr_d   = rptr_q + (ASIZE+1)'(ren);
        rempty_d = (wptr_d == rptr_d);
        // Full: same slot, opposite lap.
        wfull_d  = (wptr_d == {~rptr_d[ASIZE], rptr_d[ASIZE-1:0]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
        end
    end

    fifo_mem #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_mem (
        .clk   (clk),
        .wclken(wen),
        .waddr (wptr_q[ASIZE-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr_q[ASIZE-1:0]),
        .rdata (rdata)
    );

    assign bus.rdata  = rdata;
    assign bus.wfull  = wfull_q;
    assign bus.rempty = rempty_q;
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: directed checks of the FWFT FIFO (DSIZE=8, ASIZE=3).
module tb_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    fifo_if #(.DSIZE(8)) bus ();

    fifo #(.DSIZE(8), .ASIZE(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       e_empty;
        logic       e_full;
        logic       chk_d;
        logic [7:0] e_d;
        string      nm;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] model[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void addv(input logic w, input logic [7:0] d, input logic r,
                                 input logic ee, input logic ef, input logic cd,
                                 input logic [7:0] ed, input string nm);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.e_empty = ee; v.e_full = ef;
        v.chk_d = cd; v.e_d = ed; v.nm = nm;
        vecs.push_back(v);
    endfunction

    // Drive inputs away from the edge, then sample just after it.
    task automatic drive_edge(input logic w, input logic [7:0] d, input logic r);
        @(negedge clk);
        bus.winc  = w;
        bus.wdata = d;
        bus.rinc  = r;
        @(posedge clk);
        #1;
    endtask

    // Behavioural occupancy model for the longer sequences.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input string nm);
        bit do_w, do_r;
        do_w = w && (model.size() < 8);
        do_r = r && (model.size() > 0);
        drive_edge(w, d, r);
        if (do_r) void'(model.pop_front());
        if (do_w) model.push_back(d);
        chk({nm, ".rempty"}, 32'(bus.rempty), 32'(model.size() == 0));
        chk({nm, ".wfull"}, 32'(bus.wfull), 32'(model.size() == 8));
        if (model.size() > 0) chk({nm, ".rdata"}, 32'(bus.rdata), 32'(model[0]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model.delete();
    endtask

    initial begin
        bus.winc  = 1'b0;
        bus.rinc  = 1'b0;
        bus.wdata = 8'h00;

        // Streaming with rinc held high; writes on alternate cycles.
        addv(1, 8'h24, 1, 0, 0, 1, 8'h24, "stream_w24");
        addv(0, 8'h00, 1, 1, 0, 0, 8'h00, "stream_p24");
        addv(1, 8'h81, 1, 0, 0, 1, 8'h81, "stream_w81");
        addv(0, 8'h00, 1, 1, 0, 0, 8'h00, "stream_p81");
        addv(1, 8'h09, 1, 0, 0, 1, 8'h09, "stream_w09");
        addv(0, 8'h00, 1, 1, 0, 0, 8'h00, "stream_p09");
        // Fill: 11 writes, last three dropped; head stays 0x00.
        for (int i = 0; i < 11; i++)
            addv(1, 8'(i), 0, 0, (i >= 7), 1, 8'h00, $sformatf("fill%0d", i));
        // Drain: 11 reads; head advances 0x01..0x07 then empty.
        for (int k = 0; k < 11; k++)
            addv(0, 8'h00, 1, (k >= 7), 0, (k < 7), 8'(k + 1), $sformatf("drain%0d", k));
        // Pointers unchanged by over-reads: next write is the head.
        addv(1, 8'h55, 0, 0, 0, 1, 8'h55, "post_drain_w");
        addv(0, 8'h00, 1, 1, 0, 0, 8'h00, "post_drain_r");

        // Reset held for 2 cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rempty", 32'(bus.rempty), 32'd1);
        chk("reset.wfull", 32'(bus.wfull), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive_edge(vecs[i].w, vecs[i].d, vecs[i].r);
            chk({vecs[i].nm, ".rempty"}, 32'(bus.rempty), 32'(vecs[i].e_empty));
            chk({vecs[i].nm, ".wfull"}, 32'(bus.wfull), 32'(vecs[i].e_full));
            if (vecs[i].chk_d) chk({vecs[i].nm, ".rdata"}, 32'(bus.rdata), 32'(vecs[i].e_d));
        end

        // Four stored, then 20 cycles of simultaneous read+write across wrap.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, "sim_pre");
        for (int i = 0; i < 20; i++) step(1, 8'hB0 + 8'(i), 1, $sformatf("sim%0d", i));
        chk("sim.occupancy", 32'(model.size()), 32'd4);

        // Full: simultaneous ops perform only the read.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 8'hC0 + 8'(i), 0, "full_pre");
        chk("full_pre.wfull", 32'(bus.wfull), 32'd1);
        step(1, 8'hEE, 1, "full_wr");
        chk("full_wr.wfull_drop", 32'(bus.wfull), 32'd0);
        chk("full_wr.head", 32'(bus.rdata), 32'hC1);

        // Empty: simultaneous ops perform only the write.
        do_reset();
        step(1, 8'h3C, 1, "empty_wr");
        chk("empty_wr.rempty_drop", 32'(bus.rempty), 32'd0);
        chk("empty_wr.head", 32'(bus.rdata), 32'h3C);

        // Three full fill/drain passes with distinct data.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) step(1, 8'(p * 16 + i + 8'h10), 0, $sformatf("wrap%0d_w", p));
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("wrap%0d_rd%0d", p, i), 32'(bus.rdata), 32'(p * 16 + i + 8'h10));
                step(0, 8'h00, 1, $sformatf("wrap%0d_r", p));
            end
            chk($sformatf("wrap%0d_empty", p), 32'(bus.rempty), 32'd1);
        end

        // Asynchronous reset mid-stream with 3 entries stored.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0, "arst_pre");
        @(negedge clk);
        bus.winc = 1'b0;
        bus.rinc = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.rempty", 32'(bus.rempty), 32'd1);
        chk("arst.wfull", 32'(bus.wfull), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        step(1, 8'h77, 0, "arst_post");
        chk("arst_post.addr0", 32'(dut.u_mem.mem_q[0]), 32'h77);
        step(0, 8'h00, 1, "arst_post_r");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
